multicycle_shifter: RTL and testbench
=====================================

// Module: multicycle_shifter
// PURPOSE
//  Sequential, parametrised successor to the combinational N-bit right shifter in the ALU.
//  Performs LSR, LSL and ASR (plus ROR when enabled) on an N-bit operand.
//  Shifts by at most STEP bit positions per cycle, so area is traded against latency.
//  Uses a valid/ready handshake on both sides and returns the result with n,z,v,c flags.
// PARAMETERS
//  N      8  operand/result width in bits (N >= 2)
//  STEP   2  maximum bit positions shifted per cycle (1 <= STEP <= N)
//  SHW    $clog2(N)+1  width of the shift-amount field (derived; do not override)
// PORTS
//  clk            in   1    clock, rising edge
//  rst_n          in   1    synchronous active-low reset
//  in_valid       in   1    request valid
//  in_ready       out  1    block can accept a request (high only in IDLE)
//  in_a           in   N    operand
//  in_shift       in   SHW  shift amount
//  in_mode        in   2    00 LSR, 01 LSL, 10 ASR, 11 ROR/LSR (see CONFIGURATION)
//  out_valid      out  1    result valid
//  out_ready      in   1    consumer accepts result
//  out            out  N    result
//  flags_n_z_v_c  out  4    {N,Z,V,C}, qualified by out_valid
// BEHAVIOUR
//  - Reset: all logic is synchronous and active-low. Every posedge with rst_n=0 gives:
//    state=IDLE; out, flags_n_z_v_c and out_valid = 0.
//    Any in-flight operation is dropped. in_ready=1 from the first reset edge onward.
//  - FSM states: IDLE, SHIFT, DONE.
//    IDLE: in_ready=1. On in_valid&&in_ready, capture in_a, in_mode and the amount.
//      Clear C and the V-tracking bit. Go to SHIFT if amount != 0, else DONE.
//    SHIFT: each cycle shift by k = min(remaining, STEP), then remaining -= k.
//      C = last bit shifted out in this step.
//      LSL: V |= (MSB changes at any intermediate bit position).
//      Go to DONE when remaining becomes 0.
//    DONE: out_valid=1; out and flags are held stable.
//      On out_ready, return to IDLE. New requests are not accepted in SHIFT or DONE.
//  - Latency from accept edge to out_valid: 1 + ceil(amount/STEP) cycles.
//    Amount 0 gives 1 cycle. There is no back-to-back overlap.
//  - Amount rules:
//    LSR/LSL/ASR: amount > N saturates to N. N gives 0 for LSR/LSL, or N copies of the
//    sign bit for ASR. C is still the last bit shifted out.
//    ROR: amount is taken mod N.
//  - Flags:
//    N = out[N-1]; Z = (out == 0).
//    V = MSB-change tracking for LSL only; 0 for all other modes.
//    C = last bit out; 0 when amount is 0. For ROR, C = out[N-1] when amount != 0.
//  - Simultaneous events:
//    in_valid while not IDLE is ignored; the requester must hold it.
//    out_ready outside DONE has no effect.
//    rst_n=0 overrides every other input.
// CONFIGURATION
//  SHIFTER_ROTATE_EN defined: mode 11 = rotate right, using the ROR rules above.
//  SHIFTER_ROTATE_EN undefined: mode 11 behaves exactly as LSR (00). No rotate logic is built.
// STRUCTURE
//  Shared package/header shifter_defs:
//    mode codes MODE_LSR/LSL/ASR/ROR, state encodings IDLE/SHIFT/DONE,
//    flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0.
//  One sub-module, shift_step (combinational): shifts by 0..STEP in the current mode and
//  returns the new value, the last bit out and the MSB-change bit.
//  The top level holds the FSM, the remaining counter and the result/flag registers.
// TESTING (N=8, STEP=2 unless stated)
//  1. LSR in_a=8'b11110000, shift=3 -> out=8'b00011110, flags=4'b0000, out_valid 3 cycles after accept.
//  2. ASR in_a=8'b10010000, shift=6 -> out=8'b11111110, flags=4'b1000, latency 4.
//  3. LSL in_a=8'b01000001, shift=1 -> out=8'b10000010, flags=4'b1010.
//     LSR in_a=8'h80, shift=8 -> out=0, flags=4'b0101.
//  4. shift=0, in_a=8'hA5 -> out=8'hA5, flags=4'b1000, latency 1.
//     shift=15, LSL in_a=8'hFF -> saturates to 8 -> out=0, Z=1, C=1.
//  5. Backpressure: out_ready=0 for 5 cycles in DONE -> out and flags stable, in_ready=0,
//     and a second in_valid is not captured until after the out_ready handshake.
//  6. rst_n=0 for one edge mid-SHIFT -> next cycle out_valid=0, out=0, in_ready=1.
//     With SHIFTER_ROTATE_EN: mode 11, in_a=8'h81, shift=1 -> 8'hC0, flags=4'b1001.
//     Without it: same stimulus -> 8'h40, flags=4'b0001.

Source files
------------

// File: rtl/multicycle_shifter_pkg.sv
// Shared definitions for multicycle_shifter and shift_step:
// mode codes, FSM state encodings and flag bit positions within flags_n_z_v_c.
package shifter_defs;

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_LSL = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROR = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/multicycle_shifter_shift_step.sv
// Combinational shifter slice: moves the value by 0..STEP positions in the given mode.
// Rotate support is built only when SHIFTER_ROTATE_EN is defined.
module shift_step
    import shifter_defs::*;
#(
    parameter int N    = 8,
    parameter int STEP = 2,
    parameter int SHW  = $clog2(N) + 1
) (
    input  logic [N-1:0]   value,
    input  mode_t          mode,
    input  logic [SHW-1:0] amount,
    output logic [N-1:0]   result,
    output logic           last_out,
    output logic           msb_change
);

    // Unrolled chain of single-bit shifts; stages at or beyond 'amount' pass through.
    always_comb begin
        result     = value;
        last_out   = 1'b0;
        msb_change = 1'b0;
        for (int i = 0; i < STEP; i++) begin
            if (SHW'(i) < amount) begin
                case (mode)
                    MODE_LSL: begin
                        last_out   = result[N-1];
                        msb_change = msb_change | (result[N-1] ^ result[N-2]);
                        result     = {result[N-2:0], 1'b0};
                    end
                    MODE_ASR: begin
                        last_out = result[0];
                        result   = {result[N-1], result[N-1:1]};
                    end
`ifdef SHIFTER_ROTATE_EN
                    MODE_ROR: begin
                        last_out = result[0];
                        result   = {result[0], result[N-1:1]};
                    end
`endif
                    default: begin
                        last_out = result[0];
                        result   = {1'b0, result[N-1:1]};
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/multicycle_shifter.sv
// Sequential LSR/LSL/ASR shifter moving at most STEP bits per cycle, valid/ready on both sides.
// Define SHIFTER_ROTATE_EN to make mode 11 a rotate right; otherwise mode 11 acts as LSR.
module multicycle_shifter
    import shifter_defs::*;
#(
    parameter  int N    = 8,
    parameter  int STEP = 2,
    localparam int SHW  = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in_a,
    input  logic [SHW-1:0] in_shift,
    input  logic [1:0]     in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out,
    output logic [3:0]     flags_n_z_v_c
);

    localparam logic [SHW-1:0] N_AMT    = SHW'(N);
    localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);

    state_t         state_q, state_nxt;
    mode_t          mode_q, mode_nxt, req_mode;
    logic [N-1:0]   value_q, value_nxt;
    logic [SHW-1:0] rem_q, rem_nxt, req_amount, step_amount;
    logic           c_q, c_nxt, v_q, v_nxt, valid_q, valid_nxt;
    logic [3:0]     flags_q, flags_nxt;
    logic [N-1:0]   step_result;
    logic           step_last, step_msb_change;

    // Normalise the request: fold mode 11 when rotate is absent, clamp or wrap the amount.
    always_comb begin
`ifdef SHIFTER_ROTATE_EN
        req_mode = mode_t'(in_mode);
        if (req_mode == MODE_ROR)
            req_amount = in_shift % N_AMT;
        else if (in_shift > N_AMT)
            req_amount = N_AMT;
        else
            req_amount = in_shift;
`else
        req_mode = (in_mode == MODE_ROR) ? MODE_LSR : mode_t'(in_mode);
        if (in_shift > N_AMT)
            req_amount = N_AMT;
        else
            req_amount = in_shift;
`endif
    end

    assign step_amount = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;

    shift_step #(.N(N), .STEP(STEP), .SHW(SHW)) u_step (
        .value      (value_q),
        .mode       (mode_q),
        .amount     (step_amount),
        .result     (step_result),
        .last_out   (step_last),
        .msb_change (step_msb_change)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_LSR;
            value_q <= '0;
            rem_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            valid_q <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_nxt;
            mode_q  <= mode_nxt;
            value_q <= value_nxt;
            rem_q   <= rem_nxt;
            c_q     <= c_nxt;
            v_q     <= v_nxt;
            valid_q <= valid_nxt;
            flags_q <= flags_nxt;
        end
    end

    // DONE spends its first cycle registering the flags, so out_valid rises one cycle after entry.
    always_comb begin
        state_nxt = state_q;
        mode_nxt  = mode_q;
        value_nxt = value_q;
        rem_nxt   = rem_q;
        c_nxt     = c_q;
        v_nxt     = v_q;
        valid_nxt = valid_q;
        flags_nxt = flags_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    value_nxt = in_a;
                    mode_nxt  = req_mode;
                    rem_nxt   = req_amount;
                    c_nxt     = 1'b0;
                    v_nxt     = 1'b0;
                    state_nxt = (req_amount == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                value_nxt = step_result;
                c_nxt     = step_last;
                v_nxt     = v_q | (step_msb_change & (mode_q == MODE_LSL));
                rem_nxt   = rem_q - step_amount;
                if (rem_q == step_amount)
                    state_nxt = DONE;
            end
            DONE: begin
                if (!valid_q) begin
                    valid_nxt         = 1'b1;
                    flags_nxt[FLAG_N] = value_q[N-1];
                    flags_nxt[FLAG_Z] = (value_q == '0);
                    flags_nxt[FLAG_V] = v_q;
                    flags_nxt[FLAG_C] = c_q;
                end else if (out_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = valid_q;
    assign out           = value_q;
    assign flags_n_z_v_c = flags_q;

endmodule

// File: tb/tb_multicycle_shifter.sv
// Self-checking bench for multicycle_shifter (N=8, STEP=2): directed table, hand sequences, random vs model.
// Honours SHIFTER_ROTATE_EN for the expected behaviour of mode 11.
module tb_multicycle_shifter;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [3:0] in_shift;
    logic [1:0] in_mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic [3:0] flags_n_z_v_c;

    int pass_count  = 0;
    int check_count = 0;

    typedef struct {
        logic [7:0] a;
        logic [3:0] sh;
        logic [1:0] md;
        logic [7:0] exp_out;
        logic [3:0] exp_flags;
        int         exp_lat;
    } vec_t;

    vec_t vecs[9];

    multicycle_shifter #(.N(8), .STEP(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_shift      (in_shift),
        .in_mode       (in_mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out           (out),
        .flags_n_z_v_c (flags_n_z_v_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp)
            pass_count++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model straight from the shift rules, using whole-word operators.
    function automatic void model(input logic [7:0] a, input logic [3:0] sh, input logic [1:0] md,
                                  output logic [7:0] r, output logic [3:0] f, output int lat);
        int s;
        logic c, v;
        logic [1:0] m;
        logic [15:0] d;
        m = md;
`ifndef SHIFTER_ROTATE_EN
        if (m == 2'b11) m = 2'b00;
`endif
        if (m == 2'b11) s = int'(sh) % 8;
        else            s = (int'(sh) > 8) ? 8 : int'(sh);
        c = 1'b0;
        v = 1'b0;
        d = '0;
        case (m)
            2'b00: begin
                r = a >> s;
                if (s > 0) c = a[s-1];
            end
            2'b01: begin
                r = a << s;
                if (s > 0) c = a[8-s];
                for (int j = 1; j <= s; j++)
                    if (((j <= 7) ? a[7-j] : 1'b0) != a[7]) v = 1'b1;
            end
            2'b10: begin
                r = $signed(a) >>> s;
                if (s > 0) c = a[s-1];
            end
            default: begin
                d = {a, a} >> s;
                r = d[7:0];
                if (s > 0) c = r[7];
            end
        endcase
        f = {r[7], (r == 8'h00), v, c};
        lat = 1 + (s + 1) / 2;
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic apply_stimulus(input string name, input logic [7:0] a, input logic [3:0] sh,
                                  input logic [1:0] md, input logic [7:0] exp_out,
                                  input logic [3:0] exp_flags, input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        check_output({name, " in_ready"}, 32'(in_ready), 32'd1);
        in_a     = a;
        in_shift = sh;
        in_mode  = md;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check_output({name, " latency"}, 32'(lat), 32'(exp_lat));
        check_output({name, " out"}, 32'(out), 32'(exp_out));
        check_output({name, " flags"}, 32'(flags_n_z_v_c), 32'(exp_flags));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check_output({name, " hold out"}, 32'(out), 32'(exp_out));
            check_output({name, " hold flags"}, 32'(flags_n_z_v_c), 32'(exp_flags));
            check_output({name, " hold in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_output({name, " valid drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] ra, rexp;
        logic [3:0] rsh, rflags;
        logic [1:0] rmd;
        int rlat, lat;

        vecs[0] = '{8'hF0, 4'd3,  2'b00, 8'h1E, 4'b0000, 3};
        vecs[1] = '{8'h90, 4'd6,  2'b10, 8'hFE, 4'b1000, 4};
        vecs[2] = '{8'h41, 4'd1,  2'b01, 8'h82, 4'b1010, 2};
        vecs[3] = '{8'h80, 4'd8,  2'b00, 8'h00, 4'b0101, 5};
        vecs[4] = '{8'hA5, 4'd0,  2'b00, 8'hA5, 4'b1000, 1};
        vecs[5] = '{8'hFF, 4'd15, 2'b01, 8'h00, 4'b0111, 5};
        vecs[6] = '{8'h7F, 4'd8,  2'b10, 8'h00, 4'b0100, 5};
        vecs[7] = '{8'h01, 4'd7,  2'b01, 8'h80, 4'b1010, 5};
`ifdef SHIFTER_ROTATE_EN
        vecs[8] = '{8'h81, 4'd1,  2'b11, 8'hC0, 4'b1001, 2};
`else
        vecs[8] = '{8'h81, 4'd1,  2'b11, 8'h40, 4'b0001, 2};
`endif

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_shift  = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset in_ready", 32'(in_ready), 32'd1);
        check_output("reset out_valid", 32'(out_valid), 32'd0);
        check_output("reset out", 32'(out), 32'd0);
        check_output("reset flags", 32'(flags_n_z_v_c), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++)
            apply_stimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].sh, vecs[i].md,
                           vecs[i].exp_out, vecs[i].exp_flags, vecs[i].exp_lat, i % 2);

        // Backpressure with a second request held on in_valid throughout DONE.
        @(negedge clk);
        in_a = 8'hF0; in_shift = 4'd3; in_mode = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_a = 8'h33; in_shift = 4'd1; in_mode = 2'b01;
        wait_valid(lat);
        check_output("bp latency", 32'(lat), 32'd3);
        for (int h = 0; h < 5; h++) begin
            @(posedge clk);
            #1;
            check_output("bp out", 32'(out), 32'h1E);
            check_output("bp flags", 32'(flags_n_z_v_c), 32'd0);
            check_output("bp in_ready", 32'(in_ready), 32'd0);
            check_output("bp out_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_output("bp released valid", 32'(out_valid), 32'd0);
        check_output("bp released in_ready", 32'(in_ready), 32'd1);
        check_output("bp not yet captured", 32'(out), 32'h1E);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(lat);
        check_output("bp second latency", 32'(lat), 32'd2);
        check_output("bp second out", 32'(out), 32'h66);
        check_output("bp second flags", 32'(flags_n_z_v_c), 32'b0000);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset asserted for one edge while a long shift is in progress.
        @(negedge clk);
        in_a = 8'hFF; in_shift = 4'd8; in_mode = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("midreset out_valid", 32'(out_valid), 32'd0);
        check_output("midreset out", 32'(out), 32'd0);
        check_output("midreset flags", 32'(flags_n_z_v_c), 32'd0);
        check_output("midreset in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus("post reset", vecs[8].a, vecs[8].sh, vecs[8].md,
                       vecs[8].exp_out, vecs[8].exp_flags, vecs[8].exp_lat, 0);

        for (int t = 0; t < 40; t++) begin
            ra  = 8'($urandom);
            rsh = 4'($urandom_range(0, 15));
            rmd = 2'($urandom_range(0, 3));
            model(ra, rsh, rmd, rexp, rflags, rlat);
            apply_stimulus($sformatf("rand%0d a=%0h sh=%0d md=%0d", t, ra, rsh, rmd),
                           ra, rsh, rmd, rexp, rflags, rlat, int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
